// File: rtl/bpsk_nco_pkg.sv
// Shared definitions for the BPSK NCO family: quadrant encoding, the
// elaboration-time quarter-wave sine table generator and a width check.
package bpsk_nco_pkg;

    // Phase quadrant encoding: the top two bits of the table address
    localparam logic [1:0] QUAD_0   = 2'd0;
    localparam logic [1:0] QUAD_90  = 2'd1;
    localparam logic [1:0] QUAD_180 = 2'd2;
    localparam logic [1:0] QUAD_270 = 2'd3;

    // True when a peak magnitude fits a signed word with room to negate
    function automatic bit amplitude_fits(int amplitude, int data_w);
        return (amplitude >= 0) && (amplitude <= ((1 << (data_w - 1)) - 1));
    endfunction

    // round(amplitude * sin(pi/2 * k / 2^lut_aw)), evaluated in Q28 fixed
    // point with a Taylor series so no real arithmetic reaches synthesis
    function automatic int quarter_sine(int amplitude, int lut_aw, int k);
        longint scale;
        longint pi_s;
        longint x;
        longint term;
        longint sum;
        scale = longint'(1) << 28;
        pi_s  = longint'(843314857);
        x     = (pi_s * longint'(k)) / (longint'(2) << lut_aw);
        term  = x;
        sum   = x;
        for (int n = 1; n <= 7; n++) begin
            term = (term * x) / scale;
            term = (term * x) / scale;
            term = -term / longint'((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        return int'((longint'(amplitude) * sum + scale / 2) / scale);
    endfunction

endpackage

// File: rtl/quarter_sine_rom.sv
// Registered quarter-wave sine lookup.
// Ports: clk, rst_n; quad/index select the phase point; mag is the
// registered unsigned magnitude, neg flags the lower half-wave (q2/q3).
module quarter_sine_rom
    import bpsk_nco_pkg::*;
#(
    parameter int unsigned LUT_AW    = 6,
    parameter int unsigned MAG_W     = 7,
    parameter int unsigned AMPLITUDE = 77
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        quad,
    input  logic [LUT_AW-1:0] index,
    output logic [MAG_W-1:0]  mag,
    output logic              neg
);

    localparam int unsigned N      = 2 ** LUT_AW;
    localparam int unsigned ADDR_W = LUT_AW + 1;

    logic [MAG_W-1:0]  sine_tab [N+1];
    logic [ADDR_W-1:0] addr;
    logic              mirror;
    logic              neg_q;

    // N+1 entries so the mirrored index N-i reaches the peak at i=0
    for (genvar k = 0; k <= N; k++) begin : g_tab
        localparam int ENTRY = quarter_sine(int'(AMPLITUDE), int'(LUT_AW), k);
        assign sine_tab[k] = MAG_W'(ENTRY);
    end

    // Odd quadrants read the table backwards, lower half-wave is negated
    always_comb begin
        mirror = (quad == QUAD_90) || (quad == QUAD_270);
        neg_q  = (quad == QUAD_180) || (quad == QUAD_270);
        addr   = mirror ? (ADDR_W'(N) - ADDR_W'(index)) : ADDR_W'(index);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag <= '0;
            neg <= 1'b0;
        end else begin
            mag <= sine_tab[addr];
            neg <= neg_q;
        end
    end

endmodule

// File: rtl/bpsk_nco_gen.sv
// Phase-accumulator sine NCO with BPSK phase inversion at carrier-cycle
// boundaries. Fixed two-cycle latency from accumulator to data_out.
// Ports: clk, rst_n; en advances the phase; ftw_in/ftw_load set the tuning
// word; mod_en enables BPSK; bit_in/bit_valid/bit_ready form the bit
// handshake; data_out/data_valid/cycle_start carry samples; underrun
// pulses when a boundary finds no pending bit.
module bpsk_nco_gen
    import bpsk_nco_pkg::*;
#(
    parameter int unsigned PHASE_W   = 16,
    parameter int unsigned LUT_AW    = 6,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned AMPLITUDE = 77,
    parameter int unsigned FTW_RESET = 16384
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [PHASE_W-1:0]       ftw_in,
    input  logic                     ftw_load,
    input  logic                     mod_en,
    input  logic                     bit_in,
    input  logic                     bit_valid,
    output logic                     bit_ready,
    output logic signed [DATA_W-1:0] data_out,
    output logic                     data_valid,
    output logic                     cycle_start,
    output logic                     underrun
);

    localparam int unsigned A_W   = LUT_AW + 2;
    localparam int unsigned MAG_W = DATA_W - 1;

    if (!amplitude_fits(int'(AMPLITUDE), int'(DATA_W))) begin : g_bad_amplitude
        $error("bpsk_nco_gen: AMPLITUDE does not fit signed DATA_W");
    end
    if (PHASE_W < A_W) begin : g_bad_phase_w
        $error("bpsk_nco_gen: PHASE_W narrower than LUT_AW+2");
    end

    logic [PHASE_W-1:0] acc;
    logic [PHASE_W-1:0] ftw;
    logic [PHASE_W:0]   acc_sum;
    logic               boundary;
    logic               accept;
    logic               wrap;
    logic               cur_bit;
    logic               pend;
    logic [A_W-1:0]     phase_addr;

    logic [MAG_W-1:0]         s1_mag;
    logic                     s1_neg_q;
    logic                     s1_flip;
    logic                     s1_wrap;
    logic                     s1_en;
    logic signed [DATA_W-1:0] s1_mag_s;

    assign acc_sum    = {1'b0, acc} + {1'b0, ftw};
    assign boundary   = en & acc_sum[PHASE_W];
    assign accept     = bit_valid & bit_ready;
    assign phase_addr = acc[PHASE_W-1 -: A_W];

    // Phase accumulator; wrap marks the phase value that opens a new cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc  <= '0;
            ftw  <= PHASE_W'(FTW_RESET);
            wrap <= 1'b1;
        end else begin
            if (en) begin
                acc  <= acc_sum[PHASE_W-1:0];
                wrap <= acc_sum[PHASE_W];
            end
            if (ftw_load) begin
                ftw <= ftw_in;
            end
        end
    end

    // One-deep bit slot; bits only move into cur_bit at a carrier boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_bit   <= 1'b0;
            pend      <= 1'b0;
            bit_ready <= 1'b1;
            underrun  <= 1'b0;
        end else begin
            underrun <= 1'b0;
            if (boundary) begin
                if (!bit_ready) begin
                    cur_bit   <= pend;
                    bit_ready <= 1'b1;
                end else if (accept) begin
                    cur_bit <= bit_in;
                end else begin
                    underrun <= mod_en;
                end
            end else if (accept) begin
                pend      <= bit_in;
                bit_ready <= 1'b0;
            end
        end
    end

    quarter_sine_rom #(
        .LUT_AW    (LUT_AW),
        .MAG_W     (MAG_W),
        .AMPLITUDE (AMPLITUDE)
    ) u_rom (
        .clk   (clk),
        .rst_n (rst_n),
        .quad  (phase_addr[A_W-1 -: 2]),
        .index (phase_addr[LUT_AW-1:0]),
        .mag   (s1_mag),
        .neg   (s1_neg_q)
    );

    // Stage 1 side-band: BPSK flip, cycle-start marker and sample valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_flip <= 1'b0;
            s1_wrap <= 1'b0;
            s1_en   <= 1'b0;
        end else begin
            s1_flip <= cur_bit & mod_en;
            s1_wrap <= wrap;
            s1_en   <= en;
        end
    end

    assign s1_mag_s = $signed({1'b0, s1_mag});

    // Stage 2: signed sample; data_out holds between valid samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out    <= '0;
            data_valid  <= 1'b0;
            cycle_start <= 1'b0;
        end else begin
            data_valid  <= s1_en;
            cycle_start <= s1_wrap & s1_en;
            if (s1_en) begin
                data_out <= (s1_neg_q ^ s1_flip) ? -s1_mag_s : s1_mag_s;
            end
        end
    end

endmodule

// File: tb/tb_bpsk_nco_gen.sv
// Self-checking bench for bpsk_nco_gen: directed scenarios with fixed
// expected sequences plus a randomized run against a behavioural model.
module tb_bpsk_nco_gen;

    localparam int unsigned PHASE_W = 16;
    localparam int unsigned LUT_AW  = 6;
    localparam int unsigned DATA_W  = 8;
    localparam real         AMP     = 77.0;
    localparam real         PI      = 3.14159265358979323846;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     en = 1'b0;
    logic [PHASE_W-1:0]       ftw_in = '0;
    logic                     ftw_load = 1'b0;
    logic                     mod_en = 1'b0;
    logic                     bit_in = 1'b0;
    logic                     bit_valid = 1'b0;
    logic                     bit_ready;
    logic signed [DATA_W-1:0] data_out;
    logic                     data_valid;
    logic                     cycle_start;
    logic                     underrun;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    int unsigned m_acc, m_ftw;
    bit m_cur, m_pend, m_pfull, m_wrap;
    bit p1_valid, p1_start;
    int p1_sample;
    int o_data;
    bit o_valid, o_start, o_under;

    bpsk_nco_gen #(
        .PHASE_W   (PHASE_W),
        .LUT_AW    (LUT_AW),
        .DATA_W    (DATA_W),
        .AMPLITUDE (77),
        .FTW_RESET (16384)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .ftw_in      (ftw_in),
        .ftw_load    (ftw_load),
        .mod_en      (mod_en),
        .bit_in      (bit_in),
        .bit_valid   (bit_valid),
        .bit_ready   (bit_ready),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .cycle_start (cycle_start),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    // Ideal sine at the quantised phase (top 8 phase bits), rounded half away from zero
    function automatic int ref_sample(int unsigned acc, bit flip);
        real v;
        int  r;
        v = AMP * $sin(2.0 * PI * real'(acc >> (PHASE_W - LUT_AW - 2)) / 256.0);
        r = (v >= 0.0) ? $rtoi($floor(v + 0.5)) : -$rtoi($floor(-v + 0.5));
        return flip ? -r : r;
    endfunction

    task automatic model_reset();
        m_acc = 0; m_ftw = 16384; m_cur = 0; m_pend = 0; m_pfull = 0; m_wrap = 1;
        p1_valid = 0; p1_start = 0; p1_sample = 0;
        o_data = 0; o_valid = 0; o_start = 0; o_under = 0;
    endtask

    // Advance DUT and model by one clock; outputs are valid on return
    task automatic tick();
        int unsigned sum;
        bit carry, accept, flip, l_en, l_bit, l_load;
        int samp;
        int unsigned l_ftw_in;
        l_en = en; l_bit = bit_in; l_load = ftw_load; l_ftw_in = ftw_in;
        sum    = m_acc + (l_en ? m_ftw : 0);
        carry  = l_en && (sum >= 65536);
        accept = bit_valid && !m_pfull;
        flip   = m_cur && mod_en;
        samp   = ref_sample(m_acc, flip);
        o_under = carry && !m_pfull && !accept && mod_en;
        @(posedge clk);
        #1;
        if (p1_valid) o_data = p1_sample;
        o_valid = p1_valid;
        o_start = p1_start && p1_valid;
        p1_valid = l_en; p1_sample = samp; p1_start = m_wrap;
        if (carry) begin
            if (m_pfull) begin m_cur = m_pend; m_pfull = 0; end
            else if (accept) m_cur = l_bit;
        end else if (accept) begin
            m_pend = l_bit; m_pfull = 1;
        end
        if (l_en) begin m_acc = sum % 65536; m_wrap = carry; end
        if (l_load) m_ftw = l_ftw_in;
    endtask

    task automatic apply_reset();
        en = 0; ftw_load = 0; ftw_in = '0; mod_en = 0; bit_in = 0; bit_valid = 0;
        rst_n = 0;
        @(posedge clk);
        #1;
        rst_n = 1;
        model_reset();
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (data_out !== 8'sd0) begin errors++; $display("FAIL reset_data: got %0d want 0", data_out); end
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", data_valid); end
        checks++; if (cycle_start !== 1'b0) begin errors++; $display("FAIL reset_cstart: got %b want 0", cycle_start); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b want 0", underrun); end
        checks++; if (bit_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bit_ready); end
    endtask

    task automatic test_carrier();
        int exp_seq[4] = '{0, 77, 0, -77};
        apply_reset();
        en = 1;
        tick();
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL carrier_latency: got valid=%b want 0", data_valid); end
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL carrier_valid[%0d]: got %b want 1", i, data_valid); end
            checks++; if (int'(data_out) !== exp_seq[i % 4]) begin errors++; $display("FAIL carrier_data[%0d]: got %0d want %0d", i, data_out, exp_seq[i % 4]); end
            checks++; if (cycle_start !== logic'(i % 4 == 0)) begin errors++; $display("FAIL carrier_cstart[%0d]: got %b want %b", i, cycle_start, (i % 4 == 0)); end
        end
    endtask

    task automatic test_fine_ftw();
        int s[64];
        apply_reset();
        ftw_in = 16'd1024; ftw_load = 1;
        tick();
        ftw_load = 0; en = 1;
        tick();
        tick();
        for (int i = 0; i < 64; i++) begin
            s[i] = int'(data_out);
            checks++; if (int'(data_out) !== o_data) begin errors++; $display("FAIL fine_model[%0d]: got %0d want %0d", i, data_out, o_data); end
            tick();
        end
        checks++; if (s[16] !== 77) begin errors++; $display("FAIL fine_s16: got %0d want 77", s[16]); end
        checks++; if (s[32] !== 0) begin errors++; $display("FAIL fine_s32: got %0d want 0", s[32]); end
        checks++; if (s[48] !== -77) begin errors++; $display("FAIL fine_s48: got %0d want -77", s[48]); end
        for (int k = 0; k < 32; k++) begin
            checks++; if (s[k] !== -s[k + 32]) begin errors++; $display("FAIL fine_sym[%0d]: got %0d want %0d", k, s[k], -s[k + 32]); end
        end
    endtask

    task automatic test_bpsk();
        int exp_seq[8] = '{0, 77, 0, -77, 0, -77, 0, 77};
        apply_reset();
        en = 1; mod_en = 1;
        tick();
        bit_valid = 1; bit_in = 1;
        tick();
        bit_valid = 0; bit_in = 0;
        for (int j = 0; j < 8; j++) begin
            checks++; if (int'(data_out) !== exp_seq[j]) begin errors++; $display("FAIL bpsk_data[%0d]: got %0d want %0d", j, data_out, exp_seq[j]); end
            if (j == 0) begin
                checks++; if (bit_ready !== 1'b0) begin errors++; $display("FAIL bpsk_ready_drop: got %b want 0", bit_ready); end
            end
            if (j == 2) begin
                checks++; if (bit_ready !== 1'b1) begin errors++; $display("FAIL bpsk_ready_rise: got %b want 1", bit_ready); end
            end
            checks++; if (underrun !== logic'(j == 6)) begin errors++; $display("FAIL bpsk_underrun[%0d]: got %b want %b", j, underrun, (j == 6)); end
            tick();
        end
    endtask

    task automatic test_underrun();
        int count = 0;
        int exp_seq[4] = '{0, -77, 0, 77};
        apply_reset();
        en = 1; mod_en = 1;
        for (int t = 0; t < 8; t++) begin
            tick();
            if (underrun === 1'b1) count++;
            checks++; if (int'(data_out) !== o_data) begin errors++; $display("FAIL urun_phase[%0d]: got %0d want %0d", t, data_out, o_data); end
        end
        checks++; if (count !== 2) begin errors++; $display("FAIL urun_count: got %0d want 2", count); end
        repeat (3) tick();
        bit_valid = 1; bit_in = 1;
        tick();
        bit_valid = 0; bit_in = 0;
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL urun_direct: got %b want 0", underrun); end
        checks++; if (bit_ready !== 1'b1) begin errors++; $display("FAIL urun_direct_ready: got %b want 1", bit_ready); end
        tick();
        for (int j = 0; j < 4; j++) begin
            tick();
            checks++; if (int'(data_out) !== exp_seq[j]) begin errors++; $display("FAIL urun_applied[%0d]: got %0d want %0d", j, data_out, exp_seq[j]); end
        end
    endtask

    task automatic test_en_toggle();
        apply_reset();
        en = 1;
        tick();
        tick();
        en = 0;
        tick();
        checks++; if (data_valid !== 1'b1 || int'(data_out) !== 77) begin errors++; $display("FAIL en_before: got v=%b d=%0d want v=1 d=77", data_valid, data_out); end
        en = 1;
        tick();
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL en_gap_valid: got %b want 0", data_valid); end
        checks++; if (int'(data_out) !== 77) begin errors++; $display("FAIL en_gap_hold: got %0d want 77", data_out); end
        tick();
        checks++; if (data_valid !== 1'b1 || int'(data_out) !== 0) begin errors++; $display("FAIL en_resume0: got v=%b d=%0d want v=1 d=0", data_valid, data_out); end
        tick();
        checks++; if (int'(data_out) !== -77) begin errors++; $display("FAIL en_resume1: got %0d want -77", data_out); end
        tick();
        checks++; if (int'(data_out) !== 0 || cycle_start !== 1'b1) begin errors++; $display("FAIL en_resume2: got d=%0d cs=%b want d=0 cs=1", data_out, cycle_start); end
    endtask

    task automatic test_ftw_load();
        int exp_seq[5] = '{0, 77, 54, 0, -54};
        apply_reset();
        en = 1; ftw_in = 16'd8192; ftw_load = 1;
        tick();
        ftw_load = 0;
        for (int j = 0; j < 5; j++) begin
            tick();
            checks++; if (int'(data_out) !== exp_seq[j]) begin errors++; $display("FAIL ftw_load[%0d]: got %0d want %0d", j, data_out, exp_seq[j]); end
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        en = 1; mod_en = 1;
        tick();
        bit_valid = 1; bit_in = 1;
        tick();
        bit_valid = 0;
        tick();
        checks++; if (bit_ready !== 1'b0 || int'(data_out) !== 77) begin errors++; $display("FAIL rmid_pre: got rdy=%b d=%0d want rdy=0 d=77", bit_ready, data_out); end
        #3;
        rst_n = 0;
        #1;
        checks++; if (data_out !== 8'sd0 || data_valid !== 1'b0) begin errors++; $display("FAIL rmid_async: got d=%0d v=%b want d=0 v=0", data_out, data_valid); end
        checks++; if (bit_ready !== 1'b1 || cycle_start !== 1'b0 || underrun !== 1'b0) begin errors++; $display("FAIL rmid_flags: got rdy=%b cs=%b ur=%b want 1 0 0", bit_ready, cycle_start, underrun); end
        @(posedge clk);
        #1;
        rst_n = 1;
        model_reset();
        tick();
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL rmid_partial: got valid=%b want 0", data_valid); end
        tick();
        checks++; if (int'(data_out) !== 0 || cycle_start !== 1'b1) begin errors++; $display("FAIL rmid_restart: got d=%0d cs=%b want d=0 cs=1", data_out, cycle_start); end
        tick();
        checks++; if (int'(data_out) !== 77) begin errors++; $display("FAIL rmid_curbit: got %0d want 77", data_out); end
    endtask

    task automatic test_random();
        apply_reset();
        mod_en = 1;
        for (int c = 0; c < 3000; c++) begin
            en        = ($urandom_range(0, 9) != 0);
            ftw_load  = ($urandom_range(0, 49) == 0);
            ftw_in    = PHASE_W'($urandom_range(0, 16383));
            if ($urandom_range(0, 199) == 0) mod_en = ~mod_en;
            bit_valid = ($urandom_range(0, 3) == 0);
            bit_in    = 1'($urandom_range(0, 1));
            tick();
            checks++; if (int'(data_out) !== o_data) begin errors++; $display("FAIL rnd_data[%0d]: got %0d want %0d", c, data_out, o_data); end
            checks++; if (data_valid !== logic'(o_valid)) begin errors++; $display("FAIL rnd_valid[%0d]: got %b want %b", c, data_valid, o_valid); end
            checks++; if (cycle_start !== logic'(o_start)) begin errors++; $display("FAIL rnd_cstart[%0d]: got %b want %b", c, cycle_start, o_start); end
            checks++; if (underrun !== logic'(o_under)) begin errors++; $display("FAIL rnd_underrun[%0d]: got %b want %b", c, underrun, o_under); end
            checks++; if (bit_ready !== logic'(!m_pfull)) begin errors++; $display("FAIL rnd_ready[%0d]: got %b want %b", c, bit_ready, !m_pfull); end
        end
        en = 0; bit_valid = 0; ftw_load = 0;
    endtask

    initial begin
        test_reset();
        test_carrier();
        test_fine_ftw();
        test_bpsk();
        test_underrun();
        test_en_toggle();
        test_ftw_load();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
